// File: rtl/mem_bridge_pkg.sv
// Shared memory-map definitions for the CPU memory bridge:
// region window mask, FSM state encodings and the bus error word.
package mem_bridge_pkg;

   localparam logic [31:0] PER_WIN_MASK = 32'hFFFF_0000;
   localparam logic [31:0] DEAD_BEEF    = 32'hDEAD_BEEF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RAM_ACC,
      ST_RAM_WAIT,
      ST_PER_REQ,
      ST_UNMAP
   } state_e;

endpackage

// File: rtl/mem_addr_decode.sv
// Combinational address map decode shared by the CPU bridge and DMA.
// Exactly one of is_ram / is_per / is_unmapped is high.
module mem_addr_decode
   import mem_bridge_pkg::*;
#(
   parameter int          RAM_AW      = 14,
   parameter logic [31:0] PERIPH_BASE = 32'h0001_0000
) (
   input  logic [31:0] address,
   output logic        is_ram,
   output logic        is_per,
   output logic        is_unmapped
);

   localparam logic [32:0] RAM_END = 33'd4 << RAM_AW;
   localparam logic [31:0] PER_TAG = PERIPH_BASE & PER_WIN_MASK;

   assign is_ram      = {1'b0, address} < RAM_END;
   assign is_per      = !is_ram && ((address & PER_WIN_MASK) == PER_TAG);
   assign is_unmapped = !is_ram && !is_per;

endmodule

// File: rtl/mem_bridge.sv
// CPU re/we pulse to local RAM / valid-ready peripheral bridge.
// Define BUS_TIMEOUT_EN to bound peripheral waits at TIMEOUT_CYC cycles.
module mem_bridge
   import mem_bridge_pkg::*;
#(
   parameter int          RAM_AW      = 14,
   parameter int          RAM_LAT     = 1,
   parameter logic [31:0] PERIPH_BASE = 32'h0001_0000
`ifdef BUS_TIMEOUT_EN
   ,
   parameter int          TIMEOUT_CYC = 255
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       address,
   input  logic [31:0]       write_data,
   input  logic              re,
   input  logic              we,
   output logic [31:0]       read_data,
   output logic              mem_busy,
   output logic              bus_err,
   output logic              ram_en,
   output logic              ram_we,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata,
   output logic              per_valid,
   output logic              per_we,
   output logic [15:0]       per_addr,
   output logic [31:0]       per_wdata,
   input  logic              per_ready,
   input  logic [31:0]       per_rdata
);

   localparam int LCW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
   localparam logic [LCW-1:0] LAT_LAST = LCW'(RAM_LAT - 1);

   state_e state, state_n;

   logic              is_ram, is_per, is_unm;
   logic [RAM_AW-1:0] ram_addr_q;
   logic [15:0]       per_addr_q;
   logic [31:0]       wdata_q;
   logic              we_q;
   logic [LCW-1:0]    lat_cnt;
   logic              rd_load;
   logic [31:0]       rd_val;
   logic              err_set;

`ifdef BUS_TIMEOUT_EN
   localparam int TCW = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC + 1) : 8;
   localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT_CYC - 1);
   logic [TCW-1:0] tmo_cnt;
`endif

   mem_addr_decode #(
      .RAM_AW      (RAM_AW),
      .PERIPH_BASE (PERIPH_BASE)
   ) u_dec (
      .address     (address),
      .is_ram      (is_ram),
      .is_per      (is_per),
      .is_unmapped (is_unm)
   );

   assign ram_addr  = ram_addr_q;
   assign ram_wdata = wdata_q;
   assign per_addr  = per_addr_q;
   assign per_wdata = wdata_q;

   always_comb begin
      state_n   = state;
      mem_busy  = (state != ST_IDLE);
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      per_valid = 1'b0;
      per_we    = 1'b0;
      rd_load   = 1'b0;
      rd_val    = '0;
      err_set   = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (re || we) begin
               unique case (1'b1)
                  is_ram: state_n = ST_RAM_ACC;
                  is_per: state_n = ST_PER_REQ;
                  is_unm: state_n = ST_UNMAP;
               endcase
            end
         end
         ST_RAM_ACC: begin
            ram_en  = 1'b1;
            ram_we  = we_q;
            state_n = we_q ? ST_IDLE : ST_RAM_WAIT;
         end
         ST_RAM_WAIT: begin
            if (lat_cnt == LAT_LAST) begin
               rd_load = 1'b1;
               rd_val  = ram_rdata;
               state_n = ST_IDLE;
            end
         end
         ST_PER_REQ: begin
            per_valid = 1'b1;
            per_we    = we_q;
            if (per_ready) begin
               rd_load = !we_q;
               rd_val  = per_rdata;
               state_n = ST_IDLE;
            end
`ifdef BUS_TIMEOUT_EN
            else if (tmo_cnt == TMO_LAST) begin
               rd_load = !we_q;
               rd_val  = DEAD_BEEF;
               err_set = 1'b1;
               state_n = ST_IDLE;
            end
`endif
         end
         ST_UNMAP: begin
            rd_load = !we_q;
            err_set = 1'b1;
            state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         ram_addr_q <= '0;
         per_addr_q <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         lat_cnt    <= '0;
         read_data  <= '0;
         bus_err    <= 1'b0;
      end else begin
         state <= state_n;
         if (state == ST_IDLE && (re || we)) begin
            ram_addr_q <= address[RAM_AW+1:2];
            per_addr_q <= address[15:0];
            wdata_q    <= write_data;
            we_q       <= we;
         end
         lat_cnt <= (state == ST_RAM_WAIT) ? lat_cnt + 1'b1 : '0;
         if (rd_load) read_data <= rd_val;
         if (err_set) bus_err <= 1'b1;
      end
   end

`ifdef BUS_TIMEOUT_EN
   // Free-running only while a peripheral request is outstanding
   always_ff @(posedge clk or posedge rst) begin
      if (rst) tmo_cnt <= '0;
      else tmo_cnt <= (state == ST_PER_REQ) ? tmo_cnt + 1'b1 : '0;
   end
`endif

endmodule
